// File: rtl/raisin64_regs.sv
// Shared register-file constants for the raisin64 core: widths, the hardwired
// zero register, and writeback requester indices.
package raisin64_regs;

    localparam int RF_RW   = 6;
    localparam int RF_DW   = 64;
    localparam int RF_NREQ = 3;

    localparam logic [RF_RW-1:0] REG_ZERO = '0;

    typedef enum logic [1:0] {
        WB_ALU = 2'd0,
        WB_MEM = 2'd1,
        WB_DIV = 2'd2
    } wb_unit_e;

endpackage

// File: rtl/regfile_wb_ctrl_if.sv
// Writeback request bus from the execute units plus the regfile write port.
// master = units/regfile side, slave = the writeback controller.
interface regfile_wb_ctrl_if
    import raisin64_regs::*;
#(
    parameter int NREQ = RF_NREQ,
    parameter int DW   = RF_DW,
    parameter int RW   = RF_RW
) ();

    logic [NREQ-1:0]    req_valid;
    logic [NREQ*RW-1:0] req_rn;
    logic [NREQ*DW-1:0] req_data;
    logic [NREQ-1:0]    req_ready;
    logic               w_en;
    logic [RW-1:0]      w_rn;
    logic [DW-1:0]      w_data;

    modport master (
        output req_valid, req_rn, req_data,
        input  req_ready, w_en, w_rn, w_data
    );

    modport slave (
        input  req_valid, req_rn, req_data,
        output req_ready, w_en, w_rn, w_data
    );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after ptr (wrapping)
// wins. Outputs a one-hot grant and its encoded index.
module rr_arbiter #(
    parameter int N  = 3,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx
);

    int   cand;
    logic found;

    always_comb begin
        gnt   = '0;
        idx   = '0;
        cand  = 0;
        found = 1'b0;
        for (int k = 0; k < N; k++) begin
            cand = (int'(ptr) + k) % N;
            if (!found && req[cand]) begin
                found     = 1'b1;
                gnt[cand] = 1'b1;
                idx       = IW'(cand);
            end
        end
    end

endmodule

// File: rtl/regfile_wb_ctrl.sv
// Regfile write-port owner: round-robin writeback arbitration, registered
// write port, and a per-register pending-write scoreboard for hazard queries.
module regfile_wb_ctrl
    import raisin64_regs::*;
#(
    parameter int NREQ = RF_NREQ,
    parameter int DW   = RF_DW,
    parameter int RW   = RF_RW
) (
    input  logic                clk,
    input  logic                rst_n,
    regfile_wb_ctrl_if.slave    wb,
    input  logic                issue_en,
    input  logic [RW-1:0]       issue_rn,
    input  logic [RW-1:0]       q1_rn,
    input  logic [RW-1:0]       q2_rn,
    output logic                q1_busy,
    output logic                q2_busy,
    output logic                issue_busy,
    output logic                waw_err
);

    localparam int IW   = $clog2(NREQ);
    localparam int NREG = 1 << RW;

    logic [IW-1:0]   ptr_reg, ptr_next, gnt_idx;
    logic [NREQ-1:0] gnt;
    logic            gnt_any;
    logic [RW-1:0]   gnt_rn;
    logic [DW-1:0]   gnt_data;

    logic [NREG-1:0] pending_reg, pending_next;
    logic            waw_err_reg;
    logic            issue_nz, issue_waw;

    logic            w_en_reg;
    logic [RW-1:0]   w_rn_reg;
    logic [DW-1:0]   w_data_reg;

    rr_arbiter #(.N(NREQ), .IW(IW)) u_arb (
        .req (wb.req_valid),
        .ptr (ptr_reg),
        .gnt (gnt),
        .idx (gnt_idx)
    );

    assign wb.req_ready = gnt;
    assign gnt_any      = |gnt;
    assign gnt_rn       = wb.req_rn[gnt_idx*RW +: RW];
    assign gnt_data     = wb.req_data[gnt_idx*DW +: DW];
    assign ptr_next     = (gnt_idx == IW'(NREQ-1)) ? '0 : gnt_idx + 1'b1;

    assign issue_nz  = (issue_rn != RW'(REG_ZERO));
    assign issue_waw = issue_en && issue_nz && pending_reg[issue_rn];

    // Clear on grant first so a same-edge issue of that register re-arms it.
    always_comb begin
        pending_next = pending_reg;
        if (gnt_any)
            pending_next[gnt_rn] = 1'b0;
        if (issue_en && issue_nz && !pending_reg[issue_rn])
            pending_next[issue_rn] = 1'b1;
        pending_next[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_reg     <= '0;
            pending_reg <= '0;
            waw_err_reg <= 1'b0;
            w_en_reg    <= 1'b0;
            w_rn_reg    <= '0;
            w_data_reg  <= '0;
        end else begin
            pending_reg <= pending_next;
            waw_err_reg <= waw_err_reg | issue_waw;
            w_en_reg    <= gnt_any && (gnt_rn != RW'(REG_ZERO));
            if (gnt_any) begin
                ptr_reg    <= ptr_next;
                w_rn_reg   <= gnt_rn;
                w_data_reg <= gnt_data;
            end
        end
    end

    assign wb.w_en   = w_en_reg;
    assign wb.w_rn   = w_rn_reg;
    assign wb.w_data = w_data_reg;

    assign q1_busy    = pending_reg[q1_rn];
    assign q2_busy    = pending_reg[q2_rn];
    assign issue_busy = pending_reg[issue_rn];
    assign waw_err    = waw_err_reg;

endmodule

// File: tb/tb_regfile_wb_ctrl.sv
// Scenario bench for regfile_wb_ctrl: expected regfile writes are queued at
// grant time and compared one cycle later.
module tb_regfile_wb_ctrl;

    localparam int NREQ = 3;
    localparam int DW   = 64;
    localparam int RW   = 6;

    typedef struct packed {
        logic          en;
        logic [RW-1:0] rn;
        logic [DW-1:0] data;
    } wr_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          issue_en;
    logic [RW-1:0] issue_rn, q1_rn, q2_rn;
    logic          q1_busy, q2_busy, issue_busy, waw_err;

    int  vectors     = 0;
    int  miscompares = 0;
    wr_t exp_q[$];

    logic [RW-1:0] cur_rn   [NREQ];
    logic [DW-1:0] cur_data [NREQ];

    regfile_wb_ctrl_if #(.NREQ(NREQ), .DW(DW), .RW(RW)) wb ();

    regfile_wb_ctrl #(.NREQ(NREQ), .DW(DW), .RW(RW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .wb         (wb),
        .issue_en   (issue_en),
        .issue_rn   (issue_rn),
        .q1_rn      (q1_rn),
        .q2_rn      (q2_rn),
        .q1_busy    (q1_busy),
        .q2_busy    (q2_busy),
        .issue_busy (issue_busy),
        .waw_err    (waw_err)
    );

    always #5 clk = ~clk;

    task automatic req_set(input int u, input logic [RW-1:0] rn, input logic [DW-1:0] data);
        wb.req_valid[u]          = 1'b1;
        wb.req_rn[u*RW +: RW]    = rn;
        wb.req_data[u*DW +: DW]  = data;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        @(negedge clk);
        vectors++;
        if ({wb.w_en, wb.w_rn, wb.w_data} !== {1'b0, {RW{1'b0}}, {DW{1'b0}}}) begin
            miscompares++;
            $display("FAIL reset_wport: got en=%b rn=%0d data=%h, want 0/0/0", wb.w_en, wb.w_rn, wb.w_data);
        end else $display("reset_wport: ok");
        vectors++;
        if ({waw_err, q1_busy, q2_busy, issue_busy} !== 4'b0000) begin
            miscompares++;
            $display("FAIL reset_flags: got %b want 0000", {waw_err, q1_busy, q2_busy, issue_busy});
        end else $display("reset_flags: ok");
        rst_n = 1'b1;
    endtask

    task automatic test_single_write;
        wr_t e;
        @(negedge clk);
        req_set(1, 6'd7, 64'hDEADBEEF_00000001);
        #1;
        vectors++;
        if (wb.req_ready !== 3'b010) begin
            miscompares++;
            $display("FAIL single_ready: got %b want 010", wb.req_ready);
        end else $display("single_ready: %b", wb.req_ready);
        exp_q.push_back('{1'b1, 6'd7, 64'hDEADBEEF_00000001});
        @(negedge clk);
        wb.req_valid = '0;
        e = exp_q.pop_front();
        vectors++;
        if ({wb.w_en, wb.w_rn, wb.w_data} !== {e.en, e.rn, e.data}) begin
            miscompares++;
            $display("FAIL single_write: got en=%b rn=%0d data=%h, want en=%b rn=%0d data=%h",
                     wb.w_en, wb.w_rn, wb.w_data, e.en, e.rn, e.data);
        end else $display("single_write: rn=%0d data=%h", wb.w_rn, wb.w_data);
    endtask

    // Pointer sits at 2 here; the r0 grant to unit 2 wraps it to 0.
    task automatic test_r0_write;
        wr_t e;
        @(negedge clk);
        req_set(2, 6'd0, 64'hFFFF);
        #1;
        vectors++;
        if (wb.req_ready !== 3'b100) begin
            miscompares++;
            $display("FAIL r0_ready: got %b want 100", wb.req_ready);
        end else $display("r0_ready: %b", wb.req_ready);
        exp_q.push_back('{1'b0, 6'd0, 64'hFFFF});
        @(negedge clk);
        wb.req_valid = '0;
        e = exp_q.pop_front();
        vectors++;
        if ({wb.w_en, wb.w_rn, wb.w_data} !== {e.en, e.rn, e.data}) begin
            miscompares++;
            $display("FAIL r0_write: got en=%b rn=%0d data=%h, want en=%b rn=%0d data=%h",
                     wb.w_en, wb.w_rn, wb.w_data, e.en, e.rn, e.data);
        end else $display("r0_write: en=%b (suppressed)", wb.w_en);
    endtask

    task automatic test_round_robin;
        int  exp_g [6] = '{0, 1, 2, 0, 1, 2};
        wr_t e;
        for (int u = 0; u < NREQ; u++) begin
            cur_rn[u]   = RW'(u*8 + 1);
            cur_data[u] = {$urandom, $urandom};
        end
        for (int c = 0; c <= 6; c++) begin
            @(negedge clk);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                vectors++;
                if ({wb.w_en, wb.w_rn, wb.w_data} !== {e.en, e.rn, e.data}) begin
                    miscompares++;
                    $display("FAIL rr_write%0d: got en=%b rn=%0d data=%h, want en=%b rn=%0d data=%h",
                             c, wb.w_en, wb.w_rn, wb.w_data, e.en, e.rn, e.data);
                end else $display("rr_write%0d: rn=%0d data=%h", c, wb.w_rn, wb.w_data);
            end
            if (c < 6) begin
                for (int u = 0; u < NREQ; u++) req_set(u, cur_rn[u], cur_data[u]);
                #1;
                vectors++;
                if (wb.req_ready !== 3'(1 << exp_g[c])) begin
                    miscompares++;
                    $display("FAIL rr_grant%0d: got %b want %b", c, wb.req_ready, 3'(1 << exp_g[c]));
                end else $display("rr_grant%0d: %b", c, wb.req_ready);
                exp_q.push_back('{1'b1, cur_rn[exp_g[c]], cur_data[exp_g[c]]});
                cur_rn[exp_g[c]]   = cur_rn[exp_g[c]] + 6'd1;
                cur_data[exp_g[c]] = {$urandom, $urandom};
            end else begin
                wb.req_valid = '0;
            end
        end
    endtask

    task automatic test_scoreboard_raw;
        wr_t e;
        @(negedge clk);
        issue_en = 1'b1; issue_rn = 6'd12; q1_rn = 6'd12; q2_rn = 6'd12;
        #1;
        vectors++;
        if (q1_busy !== 1'b0) begin
            miscompares++;
            $display("FAIL raw_pre: q1_busy got %b want 0", q1_busy);
        end else $display("raw_pre: q1_busy=0");
        @(negedge clk);
        issue_en = 1'b0;
        vectors++;
        if ({q1_busy, q2_busy, issue_busy} !== 3'b111) begin
            miscompares++;
            $display("FAIL raw_set: q1/q2/issue busy got %b want 111", {q1_busy, q2_busy, issue_busy});
        end else $display("raw_set: busy=111");
        q2_rn = 6'd13;
        req_set(0, 6'd12, 64'h0123_4567_89AB_CDEF);
        #1;
        vectors++;
        if ({wb.req_ready, q1_busy, q2_busy} !== {3'b001, 1'b1, 1'b0}) begin
            miscompares++;
            $display("FAIL raw_grant: ready/q1/q2 got %b/%b/%b want 001/1/0", wb.req_ready, q1_busy, q2_busy);
        end else $display("raw_grant: ready=%b", wb.req_ready);
        exp_q.push_back('{1'b1, 6'd12, 64'h0123_4567_89AB_CDEF});
        @(negedge clk);
        wb.req_valid = '0;
        e = exp_q.pop_front();
        vectors++;
        if ({wb.w_en, wb.w_rn, wb.w_data, q1_busy} !== {e.en, e.rn, e.data, 1'b0}) begin
            miscompares++;
            $display("FAIL raw_clear: got en=%b rn=%0d data=%h q1_busy=%b, want en=%b rn=%0d data=%h q1_busy=0",
                     wb.w_en, wb.w_rn, wb.w_data, q1_busy, e.en, e.rn, e.data);
        end else $display("raw_clear: rn=%0d written, q1_busy=0", wb.w_rn);
    endtask

    task automatic test_edge_cases;
        wr_t e;
        // Untracked write to r12 on the same edge a new producer issues to r12.
        @(negedge clk);
        req_set(1, 6'd12, 64'h5555_AAAA_5555_AAAA);
        issue_en = 1'b1; issue_rn = 6'd12; q1_rn = 6'd12;
        #1;
        vectors++;
        if (wb.req_ready !== 3'b010) begin
            miscompares++;
            $display("FAIL setclr_ready: got %b want 010", wb.req_ready);
        end else $display("setclr_ready: %b", wb.req_ready);
        exp_q.push_back('{1'b1, 6'd12, 64'h5555_AAAA_5555_AAAA});
        @(negedge clk);
        wb.req_valid = '0; issue_en = 1'b0;
        e = exp_q.pop_front();
        vectors++;
        if ({wb.w_en, wb.w_rn, wb.w_data, q1_busy, waw_err} !== {e.en, e.rn, e.data, 1'b1, 1'b0}) begin
            miscompares++;
            $display("FAIL setclr: got en=%b rn=%0d q1_busy=%b waw_err=%b, want en=%b rn=%0d q1_busy=1 waw_err=0",
                     wb.w_en, wb.w_rn, q1_busy, waw_err, e.en, e.rn);
        end else $display("setclr: set wins, q1_busy=1");
        // Issue to r0 never marks pending nor flags an error.
        issue_en = 1'b1; issue_rn = 6'd0; q1_rn = 6'd0; q2_rn = 6'd0;
        @(negedge clk);
        issue_en = 1'b0;
        vectors++;
        if ({q1_busy, q2_busy, issue_busy, waw_err} !== 4'b0000) begin
            miscompares++;
            $display("FAIL r0_issue: q1/q2/issue/waw got %b want 0000", {q1_busy, q2_busy, issue_busy, waw_err});
        end else $display("r0_issue: no pending, no error");
        // WAW: r12 still pending.
        issue_en = 1'b1; issue_rn = 6'd12; q1_rn = 6'd12;
        #1;
        vectors++;
        if (issue_busy !== 1'b1) begin
            miscompares++;
            $display("FAIL waw_busy: issue_busy got %b want 1", issue_busy);
        end else $display("waw_busy: issue_busy=1");
        @(negedge clk);
        issue_en = 1'b0;
        vectors++;
        if ({waw_err, q1_busy} !== 2'b11) begin
            miscompares++;
            $display("FAIL waw_err: waw_err/q1_busy got %b want 11", {waw_err, q1_busy});
        end else $display("waw_err: set");
        req_set(2, 6'd12, 64'h1);
        #1;
        vectors++;
        if (wb.req_ready !== 3'b100) begin
            miscompares++;
            $display("FAIL waw_clr_ready: got %b want 100", wb.req_ready);
        end else $display("waw_clr_ready: %b", wb.req_ready);
        exp_q.push_back('{1'b1, 6'd12, 64'h1});
        @(negedge clk);
        wb.req_valid = '0;
        e = exp_q.pop_front();
        vectors++;
        if ({wb.w_en, wb.w_rn, wb.w_data, q1_busy, waw_err} !== {e.en, e.rn, e.data, 1'b0, 1'b1}) begin
            miscompares++;
            $display("FAIL waw_sticky: got en=%b rn=%0d q1_busy=%b waw_err=%b, want en=1 rn=12 q1_busy=0 waw_err=1",
                     wb.w_en, wb.w_rn, q1_busy, waw_err);
        end else $display("waw_sticky: waw_err stays 1");
    endtask

    task automatic test_reset_mid;
        wr_t e;
        issue_en = 1'b1; issue_rn = 6'd5; q1_rn = 6'd5;
        @(negedge clk);
        issue_en = 1'b0;
        req_set(0, 6'd9, 64'hCAFE);
        #1;
        vectors++;
        if ({wb.req_ready, q1_busy} !== {3'b001, 1'b1}) begin
            miscompares++;
            $display("FAIL mid_setup: ready/q1_busy got %b/%b want 001/1", wb.req_ready, q1_busy);
        end else $display("mid_setup: ready=%b pending5=1", wb.req_ready);
        exp_q.push_back('{1'b1, 6'd9, 64'hCAFE});
        @(negedge clk);
        wb.req_valid = '0;
        e = exp_q.pop_front();
        vectors++;
        if ({wb.w_en, wb.w_rn, wb.w_data} !== {e.en, e.rn, e.data}) begin
            miscompares++;
            $display("FAIL mid_write: got en=%b rn=%0d data=%h, want en=%b rn=%0d data=%h",
                     wb.w_en, wb.w_rn, wb.w_data, e.en, e.rn, e.data);
        end else $display("mid_write: in flight rn=%0d", wb.w_rn);
        rst_n = 1'b0;
        #1;
        vectors++;
        if ({wb.w_en, wb.w_rn, wb.w_data, q1_busy, waw_err} !== {1'b0, {RW{1'b0}}, {DW{1'b0}}, 1'b0, 1'b0}) begin
            miscompares++;
            $display("FAIL mid_reset: got en=%b rn=%0d data=%h q1_busy=%b waw_err=%b, want all 0",
                     wb.w_en, wb.w_rn, wb.w_data, q1_busy, waw_err);
        end else $display("mid_reset: state cleared");
        req_set(1, 6'd3, 64'h77);
        #1;
        vectors++;
        if (wb.req_ready !== 3'b010) begin
            miscompares++;
            $display("FAIL reset_ready: got %b want 010", wb.req_ready);
        end else $display("reset_ready: %b", wb.req_ready);
        @(negedge clk);
        wb.req_valid = '0;
        vectors++;
        if (wb.w_en !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_hold: w_en got %b want 0", wb.w_en);
        end else $display("reset_hold: no write during reset");
        rst_n = 1'b1;
        @(negedge clk);
        for (int u = 0; u < NREQ; u++) req_set(u, RW'(u + 20), DW'(u + 100));
        #1;
        vectors++;
        if (wb.req_ready !== 3'b001) begin
            miscompares++;
            $display("FAIL ptr_reset: ready got %b want 001", wb.req_ready);
        end else $display("ptr_reset: ready=%b", wb.req_ready);
        exp_q.push_back('{1'b1, 6'd20, 64'd100});
        @(negedge clk);
        wb.req_valid = '0;
        e = exp_q.pop_front();
        vectors++;
        if ({wb.w_en, wb.w_rn, wb.w_data} !== {e.en, e.rn, e.data}) begin
            miscompares++;
            $display("FAIL post_reset_write: got en=%b rn=%0d data=%h, want en=%b rn=%0d data=%h",
                     wb.w_en, wb.w_rn, wb.w_data, e.en, e.rn, e.data);
        end else $display("post_reset_write: rn=%0d", wb.w_rn);
    endtask

    initial begin
        rst_n        = 1'b0;
        wb.req_valid = '0;
        wb.req_rn    = '0;
        wb.req_data  = '0;
        issue_en     = 1'b0;
        issue_rn     = '0;
        q1_rn        = '0;
        q2_rn        = '0;
        test_reset();
        test_single_write();
        test_r0_write();
        test_round_robin();
        test_scoreboard_raw();
        test_edge_cases();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/regfile_wb_ctrl.md
Name: regfile_wb_ctrl

Overview:
- Owns the single write port of the 64x64 register file.
- Arbitrates writeback requests from NREQ execution units (ALU, load/store, mul/div) using round-robin, and registers the winning write onto the regfile w_en/w_rn/w_data port.
- Keeps a pending-write scoreboard per register so issue logic can detect RAW hazards and prevent WAW hazards.
- Sits between the execute units and the regfile; the issue stage queries it every cycle.

Parameters:
- NREQ, 3, number of writeback requesters (2..8).
- DW, 64, data width.
- RW, 6, register-number width (2^RW registers; r0 hardwired zero).

Ports:
- clk  input  1  core clock
- rst_n  input  1  asynchronous active-low reset
- req_valid  input  NREQ  writeback request per unit
- req_rn  input  NREQ*RW  destination register; unit i uses bits [i*RW +: RW]
- req_data  input  NREQ*DW  writeback data; unit i uses bits [i*DW +: DW]
- req_ready  output  NREQ  one-hot grant; combinational
- w_en  output  1  regfile write enable; registered
- w_rn  output  RW  regfile write register; registered
- w_data  output  DW  regfile write data; registered
- issue_en  input  1  issue stage dispatches an instruction that writes issue_rn
- issue_rn  input  RW  destination of the dispatched instruction
- q1_rn  input  RW  hazard query 1 (source operand 1)
- q2_rn  input  RW  hazard query 2 (source operand 2)
- q1_busy  output  1  q1_rn has a write pending; combinational
- q2_busy  output  1  q2_rn has a write pending; combinational
- issue_busy  output  1  issue_rn has a write pending (WAW); combinational
- waw_err  output  1  sticky protocol-error flag

Behaviour:
- Reset (async, rst_n low):
  - w_en=0, w_rn=0, w_data=0.
  - All pending bits cleared.
  - RR pointer=0.
  - waw_err=0.
  - req_ready follows req_valid combinationally even during reset, but no state updates.
- Arbitration (combinational):
  - Search units starting at index ptr, wrapping modulo NREQ; the first with req_valid=1 gets req_ready=1.
  - At most one grant per cycle. No backpressure from the regfile, so every cycle with any valid produces a grant.
  - A unit holds valid/rn/data stable until it sees ready.
- Pointer update: on a grant to unit g, ptr <= (g+1) mod NREQ. With no grant, ptr holds.
- Write register:
  - On a grant: w_en <= (granted rn != 0), w_rn <= granted rn, w_data <= granted data.
  - With no grant: w_en <= 0; w_rn and w_data hold.
  - Latency: grant cycle N, regfile write presented in cycle N+1.
  - A request to r0 is granted and consumed but produces w_en=0.
- Scoreboard (pending[1..2^RW-1], pending[0] always 0):
  - Set: at the edge where issue_en=1, issue_rn!=0 and pending[issue_rn]=0.
  - Clear: at the edge where a grant occurs for register rn, i.e. the bit reads 0 in cycle N+1, the same cycle w_en shows that write. The regfile's same-cycle write forwarding makes a read issued in that cycle correct.
  - Set and clear of the same register on the same edge: set wins (new producer).
  - issue_en with pending[issue_rn]=1: the issue is ignored for the scoreboard and waw_err <= 1. waw_err stays set until reset.
  - q1_busy = pending[q1_rn], q2_busy = pending[q2_rn], issue_busy = pending[issue_rn]; any query of r0 returns 0.
- Reset mid-operation: the in-flight write is dropped (w_en=0) and all pending bits clear. Requesters are reset alongside.

Decomposition:
- Shared package/header `raisin64_regs`: RW, DW, REG_ZERO constant, NREQ default, unit index constants (WB_ALU=0, WB_MEM=1, WB_DIV=2).
- One sub-module: rr_arbiter (parameter N; inputs req[N] and ptr; output one-hot gnt and encoded index). Reusable for the memory-port arbiter.
- Scoreboard stays inline.

Test Plan:
- Reset: assert rst_n=0 mid-write with pending[5]=1 -> w_en=0, q1_busy for rn=5 is 0, waw_err=0, ptr=0.
- Single write:
  - Unit1 requests rn=7, data=0xDEADBEEF_00000001 in cycle N -> req_ready=3'b010 in N.
  - In N+1: w_en=1, w_rn=7, w_data=0xDEADBEEF_00000001.
- Round-robin: all three units request continuously for 6 cycles -> grants 0,1,2,0,1,2; each unit's data appears on w_data one cycle after its grant.
- Scoreboard RAW:
  - issue_en rn=12 -> q1_busy(12)=1 from next cycle.
  - Unit0 writes rn=12 -> q1_busy(12)=0 in the cycle w_en=1, w_rn=12.
- Edge cases:
  - issue_en rn=12 on the same edge as the grant for rn=12 -> pending stays 1.
  - issue_en rn=12 while pending -> waw_err=1 and sticky.
  - issue_en rn=0 -> no pending bit set, no error.
- r0 write: unit2 requests rn=0, data=0xFFFF -> granted (req_ready[2]=1), next cycle w_en=0, and ptr advances to 0.
